// File: rtl/bus_arbiter.sv
// Two-requester arbiter and transaction sequencer for the single memory bus master.
// Instruction fetch (read-only) and load/store share the bus under 2-way round robin.
module bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,

  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_mode,
  output logic              bus_start_transaction,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_rdata_valid,
  input  logic              bus_write_done,
  output logic              bus_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_e;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              lastGrant_q, lastGrant_d;
  logic [CNT_W-1:0]    timeoutCnt_q, timeoutCnt_d;

  logic                ifGnt_q, ifGnt_d;
  logic                ifDone_q, ifDone_d;
  logic [DATA_W-1:0]   ifRdata_q, ifRdata_d;
  logic                lsGnt_q, lsGnt_d;
  logic                lsDone_q, lsDone_d;
  logic [DATA_W-1:0]   lsRdata_q, lsRdata_d;

  logic [ADDR_W-1:0]   busAddr_q, busAddr_d;
  logic [DATA_W-1:0]   busWdata_q, busWdata_d;
  logic                busMode_q, busMode_d;
  logic                busStart_q, busStart_d;
  logic                busErr_q, busErr_d;
  logic                busy_q, busy_d;

  logic                pickLs;
  logic                respOk;
  logic                finish;
  logic                finishErr;
  logic [DATA_W-1:0]   finishData;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lastGrant_d  = lastGrant_q;
    timeoutCnt_d = timeoutCnt_q;
    ifRdata_d    = ifRdata_q;
    lsRdata_d    = lsRdata_q;
    busAddr_d    = busAddr_q;
    busWdata_d   = busWdata_q;
    busMode_d    = busMode_q;
    ifGnt_d      = 1'b0;
    ifDone_d     = 1'b0;
    lsGnt_d      = 1'b0;
    lsDone_d     = 1'b0;
    busStart_d   = 1'b0;
    busErr_d     = 1'b0;
    pickLs       = 1'b0;
    respOk       = 1'b0;
    finish       = 1'b0;
    finishErr    = 1'b0;
    finishData   = '0;

    unique case (state_q)
      S_IDLE: begin
        // On a tie the requester that did not win last time gets the bus.
        pickLs = ls_req && (!if_req || (lastGrant_q == OWN_IF));
        if (if_req || ls_req) begin
          owner_d     = pickLs ? OWN_LS : OWN_IF;
          lastGrant_d = pickLs ? OWN_LS : OWN_IF;
          busAddr_d   = pickLs ? ls_addr : if_addr;
          busWdata_d  = pickLs ? ls_wdata : '0;
          busMode_d   = pickLs && ls_we;
          ifGnt_d     = !pickLs;
          lsGnt_d     = pickLs;
          busStart_d  = 1'b1;
          state_d     = S_START;
        end
      end

      S_START: begin
        timeoutCnt_d = '0;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        // Only the response matching the transaction direction counts.
        respOk = busMode_q ? bus_write_done : bus_rdata_valid;
        if (respOk) begin
          finish     = 1'b1;
          finishData = busMode_q ? '0 : bus_rdata;
        end else if (timeoutCnt_q == CNT_W'(TIMEOUT - 1)) begin
          finish    = 1'b1;
          finishErr = 1'b1;
        end else begin
          timeoutCnt_d = timeoutCnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (finish) begin
      state_d  = S_DONE;
      busErr_d = finishErr;
      if (owner_q == OWN_LS) begin
        lsDone_d  = 1'b1;
        lsRdata_d = finishData;
      end else begin
        ifDone_d  = 1'b1;
        ifRdata_d = finishData;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_IF;
      lastGrant_q  <= OWN_IF;
      timeoutCnt_q <= '0;
      ifGnt_q      <= 1'b0;
      ifDone_q     <= 1'b0;
      ifRdata_q    <= '0;
      lsGnt_q      <= 1'b0;
      lsDone_q     <= 1'b0;
      lsRdata_q    <= '0;
      busAddr_q    <= '0;
      busWdata_q   <= '0;
      busMode_q    <= 1'b0;
      busStart_q   <= 1'b0;
      busErr_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lastGrant_q  <= lastGrant_d;
      timeoutCnt_q <= timeoutCnt_d;
      ifGnt_q      <= ifGnt_d;
      ifDone_q     <= ifDone_d;
      ifRdata_q    <= ifRdata_d;
      lsGnt_q      <= lsGnt_d;
      lsDone_q     <= lsDone_d;
      lsRdata_q    <= lsRdata_d;
      busAddr_q    <= busAddr_d;
      busWdata_q   <= busWdata_d;
      busMode_q    <= busMode_d;
      busStart_q   <= busStart_d;
      busErr_q     <= busErr_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt                = ifGnt_q;
  assign if_done               = ifDone_q;
  assign if_rdata              = ifRdata_q;
  assign ls_gnt                = lsGnt_q;
  assign ls_done               = lsDone_q;
  assign ls_rdata              = lsRdata_q;
  assign bus_addr              = busAddr_q;
  assign bus_wdata             = busWdata_q;
  assign bus_mode              = busMode_q;
  assign bus_start_transaction = busStart_q;
  assign bus_err               = busErr_q;
  assign busy                  = busy_q;

endmodule
